elevator_car_ctrl: RTL and testbench

ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

---
 rtl/elevator_car_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_elevator_car_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: one car serving NUM_FLOORS floors.
// Decides on direction, steps between floors on a cycle timer, holds the door
// open for a dwell period, parks when idle and halts on emergency stop.
// Calls are owned by an external queue; this block only reports which floor
// has been serviced so that the queue can clear it.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS   = 8,
  parameter int TICK_DIV     = 10,
  parameter int TRAVEL_TICKS = 1,
  parameter int DWELL_TICKS  = 1,
  localparam int FW          = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req_pending,
  input  logic [FW-1:0]         park_floor,
  input  logic                  park_en,
  input  logic                  hold_door,
  input  logic                  estop,
  output logic [FW-1:0]         current_floor,
  output logic                  up_ndown,
  output logic                  moving,
  output logic                  door_open,
  output logic                  serviced_valid,
  output logic [FW-1:0]         serviced_floor
);

  // Cycle budgets for one floor step and for one door dwell.
  localparam int STEP_CYCLES  = TICK_DIV * TRAVEL_TICKS;
  localparam int DWELL_CYCLES = TICK_DIV * DWELL_TICKS;
  localparam int MAX_CYCLES   = (STEP_CYCLES > DWELL_CYCLES) ? STEP_CYCLES : DWELL_CYCLES;
  localparam int TW           = $clog2(MAX_CYCLES + 1);

  localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(NUM_FLOORS - 1);
  localparam logic [FW-1:0] BOT_FLOOR  = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_MOVE   = 3'd2,
    ST_DOOR   = 3'd3,
    ST_PARK   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [FW-1:0]   floor_reg, floor_next;
  logic            dir_reg, dir_next;
  logic            svc_valid_reg, svc_valid_next;
  logic [FW-1:0]   svc_floor_reg, svc_floor_next;

  // Derived decision terms
  logic [NUM_FLOORS-1:0] above_vec;
  logic [NUM_FLOORS-1:0] below_vec;
  logic                  any_req;
  logic                  req_here;
  logic                  call_ahead;
  logic                  call_behind;
  logic [FW-1:0]         park_eff;
  logic                  park_up;
  logic                  move_blocked;
  logic [FW-1:0]         move_step_floor;
  logic [FW-1:0]         park_step_floor;
  logic                  req_at_move_step;
  logic                  step_due;

  // Per-floor masks of calls strictly above and strictly below the car.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_dir_mask
    assign above_vec[gi] = req_pending[gi] && (FW'(gi) > floor_reg);
    assign below_vec[gi] = req_pending[gi] && (FW'(gi) < floor_reg);
  end

  assign any_req     = |req_pending;
  assign req_here    = req_pending[floor_reg];
  assign call_ahead  = dir_reg ? (|above_vec) : (|below_vec);
  assign call_behind = dir_reg ? (|below_vec) : (|above_vec);

  // Out-of-range park requests are clamped to the top floor.
  assign park_eff = ({1'b0, park_floor} > {1'b0, TOP_FLOOR}) ? TOP_FLOOR : park_floor;
  assign park_up  = (park_eff > floor_reg);

  // A move that would leave the shaft is refused; the car re-decides instead.
  assign move_blocked    = dir_reg ? (floor_reg == TOP_FLOOR) : (floor_reg == BOT_FLOOR);
  assign move_step_floor = dir_reg ? (floor_reg + FW'(1)) : (floor_reg - FW'(1));
  assign park_step_floor = park_up ? (floor_reg + FW'(1)) : (floor_reg - FW'(1));
  assign req_at_move_step = req_pending[move_step_floor];
  assign step_due        = (timer_reg == STEP_LAST);

  // Next-state, timer and datapath decisions for every state.
  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    floor_next     = floor_reg;
    dir_next       = dir_reg;
    svc_valid_next = 1'b0;
    svc_floor_next = svc_floor_reg;

    if (estop) begin
      // Emergency stop wins over everything, including a step due this edge.
      state_next = ST_HALT;
      timer_next = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          timer_next = '0;
          if (any_req) begin
            state_next = ST_DECIDE;
          end else if (park_en && (floor_reg != park_eff)) begin
            state_next = ST_PARK;
            dir_next   = park_up;
          end
        end

        ST_DECIDE: begin
          timer_next = '0;
          if (req_here) begin
            state_next     = ST_DOOR;
            svc_valid_next = 1'b1;
            svc_floor_next = floor_reg;
          end else if (call_ahead) begin
            state_next = ST_MOVE;
          end else if (call_behind) begin
            state_next = ST_MOVE;
            dir_next   = ~dir_reg;
          end else begin
            state_next = ST_IDLE;
          end
        end

        ST_MOVE: begin
          if (move_blocked) begin
            state_next = ST_DECIDE;
            timer_next = '0;
          end else if (step_due) begin
            floor_next = move_step_floor;
            timer_next = '0;
            if (req_at_move_step || (move_step_floor == BOT_FLOOR) ||
                (move_step_floor == TOP_FLOOR)) begin
              state_next = ST_DECIDE;
            end
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        ST_PARK: begin
          if (floor_reg == park_eff) begin
            // Park target moved onto the car while travelling.
            state_next = ST_IDLE;
            timer_next = '0;
          end else if (step_due) begin
            floor_next = park_step_floor;
            dir_next   = park_up;
            timer_next = '0;
            if (any_req) begin
              state_next = ST_DECIDE;
            end else if (park_step_floor == park_eff) begin
              state_next = ST_IDLE;
            end
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        ST_DOOR: begin
          if (hold_door) begin
            timer_next = '0;
          end else if (timer_reg == DWELL_LAST) begin
            timer_next = '0;
            state_next = any_req ? ST_DECIDE : ST_IDLE;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        ST_HALT: begin
          timer_next = '0;
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      floor_reg     <= '0;
      dir_reg       <= 1'b1;
      svc_valid_reg <= 1'b0;
      svc_floor_reg <= '0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      floor_reg     <= floor_next;
      dir_reg       <= dir_next;
      svc_valid_reg <= svc_valid_next;
      svc_floor_reg <= svc_floor_next;
    end
  end

  assign current_floor  = floor_reg;
  assign up_ndown       = dir_reg;
  assign moving         = (state_reg == ST_MOVE) || (state_reg == ST_PARK);
  assign door_open      = (state_reg == ST_DOOR);
  assign serviced_valid = svc_valid_reg;
  assign serviced_floor = svc_floor_reg;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed testbench for elevator_car_ctrl: 8 floors, 8-cycle step, 12-cycle dwell.
// The bench plays the external call queue: it clears a call when the car
// reports it serviced.
module tb_elevator_car_ctrl;
  localparam int NF = 8;
  localparam int FW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] req_pending;
  logic [FW-1:0] park_floor;
  logic          park_en;
  logic          hold_door;
  logic          estop;
  logic [FW-1:0] current_floor;
  logic          up_ndown;
  logic          moving;
  logic          door_open;
  logic          serviced_valid;
  logic [FW-1:0] serviced_floor;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int door_cycles = 0;
  int pulse_cnt = 0;
  int last_pulse_floor = -1;

  elevator_car_ctrl #(
    .NUM_FLOORS  (NF),
    .TICK_DIV    (4),
    .TRAVEL_TICKS(2),
    .DWELL_TICKS (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_pending   (req_pending),
    .park_floor    (park_floor),
    .park_en       (park_en),
    .hold_door     (hold_door),
    .estop         (estop),
    .current_floor (current_floor),
    .up_ndown      (up_ndown),
    .moving        (moving),
    .door_open     (door_open),
    .serviced_valid(serviced_valid),
    .serviced_floor(serviced_floor)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Single comparison point: counts every vector and reports a miscompare.
  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Advance to the next falling edge, sample outputs, act as the call queue.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (door_open) door_cycles++;
    if (serviced_valid) begin
      pulse_cnt++;
      last_pulse_floor = int'(serviced_floor);
      req_pending[serviced_floor] = 1'b0;
    end
  endtask

  task automatic wait_floor(input int f, input int budget);
    int n;
    n = 0;
    while ((int'(current_floor) != f) && (n < budget)) begin
      tick();
      n++;
    end
    if (int'(current_floor) != f) check_val("wait_floor_timeout", int'(current_floor), f);
  endtask

  task automatic wait_pulse(input int budget, output int fl);
    int n;
    int start;
    n = 0;
    start = pulse_cnt;
    while ((pulse_cnt == start) && (n < budget)) begin
      tick();
      n++;
    end
    if (pulse_cnt == start) check_val("wait_pulse_timeout", pulse_cnt, start + 1);
    fl = last_pulse_floor;
  endtask

  task automatic wait_door_close(input int budget);
    int n;
    n = 0;
    while (door_open && (n < budget)) begin
      tick();
      n++;
    end
    if (door_open) check_val("wait_door_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_floor"}, int'(current_floor), 0);
    check_val({pfx, "_dir"}, int'(up_ndown), 1);
    check_val({pfx, "_moving"}, int'(moving), 0);
    check_val({pfx, "_door"}, int'(door_open), 0);
    check_val({pfx, "_svc_valid"}, int'(serviced_valid), 0);
    check_val({pfx, "_svc_floor"}, int'(serviced_floor), 0);
  endtask

  initial begin
    int c0;
    int cprev;
    int fl;
    int p0;

    reset       = 1'b1;
    req_pending = '0;
    park_floor  = '0;
    park_en     = 1'b0;
    hold_door   = 1'b0;
    estop       = 1'b0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // Call at floor 3 from reset: 2 cycles latency + 3 steps of 8 cycles
    req_pending = 8'h08;
    c0 = cyc;
    door_cycles = 0;
    p0 = pulse_cnt;
    tick();
    check_val("s1_moving_in_decide", int'(moving), 0);
    tick();
    check_val("s1_moving_in_move", int'(moving), 1);
    wait_floor(3, 100);
    check_val("s1_arrive_cycles", cyc - c0, 26);
    wait_pulse(10, fl);
    check_val("s1_pulse_floor", fl, 3);
    check_val("s1_pulse_cycle", cyc - c0, 27);
    wait_door_close(100);
    check_val("s1_door_cycles", door_cycles, 12);
    tick();
    tick();
    check_val("s1_idle_moving", int'(moving), 0);
    check_val("s1_idle_floor", int'(current_floor), 3);
    check_val("s1_pulse_count", pulse_cnt - p0, 1);

    // From 3 going up with calls at 6 and 0: serve 6, reverse, serve 0
    req_pending = 8'h41;
    wait_pulse(200, fl);
    check_val("s2_first_floor", fl, 6);
    check_val("s2_first_dir", int'(up_ndown), 1);
    wait_pulse(300, fl);
    check_val("s2_second_floor", fl, 0);
    check_val("s2_second_dir", int'(up_ndown), 0);
    wait_door_close(100);

    // Door hold for 20 cycles stretches the door to 32 cycles
    door_cycles = 0;
    p0 = pulse_cnt;
    req_pending = 8'h01;
    wait_pulse(20, fl);
    check_val("s3_pulse_floor", fl, 0);
    hold_door = 1'b1;
    repeat (20) tick();
    hold_door = 1'b0;
    wait_door_close(100);
    check_val("s3_door_cycles", door_cycles, 32);
    check_val("s3_pulse_count", pulse_cnt - p0, 1);

    // Parking from 0 to 5: first step after 9 cycles, then every 8
    park_floor = 3'd5;
    park_en    = 1'b1;
    cprev = cyc;
    for (int f = 1; f <= 5; f++) begin
      wait_floor(f, 30);
      check_val($sformatf("s4_park_step%0d_cycles", f), cyc - cprev, (f == 1) ? 9 : 8);
      check_val($sformatf("s4_park_step%0d_moving", f), int'(moving), (f == 5) ? 0 : 1);
      cprev = cyc;
    end
    tick();
    tick();
    check_val("s4_parked_floor", int'(current_floor), 5);
    check_val("s4_parked_moving", int'(moving), 0);

    // Return to 0 by a call, then park again with a call at 2 during step 2->3
    park_en = 1'b0;
    req_pending = 8'h01;
    wait_pulse(200, fl);
    check_val("s4_return_floor", fl, 0);
    wait_door_close(100);
    park_en = 1'b1;
    wait_floor(2, 40);
    tick();
    req_pending[2] = 1'b1;
    park_en = 1'b0;
    wait_floor(3, 20);
    check_val("s4_decide_at3_moving", int'(moving), 0);
    check_val("s4_decide_at3_dir", int'(up_ndown), 1);
    wait_pulse(40, fl);
    check_val("s4_service_floor", fl, 2);
    check_val("s4_service_dir", int'(up_ndown), 0);
    wait_door_close(100);

    // Emergency stop between floors 4 and 5 on the way to 6
    req_pending = 8'h40;
    wait_floor(4, 100);
    repeat (4) tick();
    estop = 1'b1;
    tick();
    check_val("s5_halt_moving", int'(moving), 0);
    check_val("s5_halt_door", int'(door_open), 0);
    check_val("s5_halt_floor", int'(current_floor), 4);
    repeat (10) tick();
    check_val("s5_halt_hold_floor", int'(current_floor), 4);
    estop = 1'b0;
    tick();
    check_val("s5_release_moving", int'(moving), 0);
    check_val("s5_release_floor", int'(current_floor), 4);
    wait_pulse(100, fl);
    check_val("s5_resume_floor", fl, 6);
    tick();
    check_val("s5_door_at6", int'(door_open), 1);

    // Reset pulse mid-cycle during DOOR at floor 6
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("s6_async");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_val("s6_after_floor", int'(current_floor), 0);
    check_val("s6_after_moving", int'(moving), 0);
    check_val("s6_after_door", int'(door_open), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
